// File: rtl/fpu_pkg.sv
// Shared floating-point definitions for the FPU blocks: field widths,
// the packed single-precision layout and a helper that assembles one.
package fpu_pkg;

    localparam int EXP_BIAS = 127;
    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int INT_W    = 32;

    // IEEE-754 single, MSB first: {sign, exp, man}
    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } float_t;

    function automatic float_t pack_float(input logic             sign,
                                          input logic [EXP_W-1:0] exp,
                                          input logic [MAN_W-1:0] man);
        float_t f;
        f.sign = sign;
        f.exp  = exp;
        f.man  = man;
        return f;
    endfunction

endpackage

// File: rtl/itof_pipe_if.sv
// Operand/result handshake bundle for itof_pipe. The slave modport is the
// converter's view; the master modport is the producer/consumer side.
interface itof_pipe_if;

    logic [31:0] src;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dest;
    logic        inexact;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output src, in_valid, out_ready,
        input  in_ready, dest, inexact, out_valid
    );

    modport slave (
        input  src, in_valid, out_ready,
        output in_ready, dest, inexact, out_valid
    );

endinterface

// File: rtl/lzc32.sv
// Combinational 32-bit leading-zero counter. The count is meaningless when
// the input is zero; o_all_zero flags that case. Shared with fadd normalize.
module lzc32
    import fpu_pkg::*;
(
    input  logic [INT_W-1:0] i_data,
    output logic [4:0]       o_count,
    output logic             o_all_zero
);

    // Scan upward so the highest set bit is the last one to write the count.
    always_comb begin
        // NOTE: default assignment first, so no path leaves o_count unassigned and a latch is never inferred.
        o_count = '0;
        for (int i = 0; i < INT_W; i++) begin
            if (i_data[i]) begin
                o_count = 5'(INT_W - 1 - i);
            end
        end
    end

    assign o_all_zero = ~|i_data;

endmodule

// File: rtl/itof_pipe.sv
// Three-stage signed int32 -> IEEE-754 single converter, round-to-nearest-even.
// S1 splits sign/magnitude, S2 normalizes, S3 rounds and packs. All stages
// advance together whenever the output register is empty or being drained.
module itof_pipe
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    itof_pipe_if.slave  bus
);

    // Stage valid bits
    logic r_s1_valid, r_s2_valid, r_s3_valid;

    // S1: sign / magnitude
    logic             r_s1_sign;
    logic [INT_W-1:0] r_s1_mag;

    // S2: normalized magnitude and pre-round exponent
    logic             r_s2_sign;
    logic             r_s2_zero;
    logic [INT_W-1:0] r_s2_norm;
    logic [EXP_W-1:0] r_s2_exp;

    // S3: packed result
    float_t r_dest;
    logic   r_inexact;

    logic             w_adv;
    logic [4:0]       w_lz;
    logic             w_all_zero;
    logic [INT_W-1:0] w_norm;
    logic [23:0]      w_man24;
    logic             w_guard;
    logic             w_sticky;
    logic             w_round_up;
    logic [24:0]      w_sum;
    logic [EXP_W-1:0] w_exp_rnd;
    logic [MAN_W-1:0] w_man_rnd;

    // A full output register that is not being taken freezes the whole pipe.
    assign w_adv        = !r_s3_valid || bus.out_ready;
    assign bus.in_ready = w_adv || rst;

    // Valid chain: cleared by reset, shifted as one on every advance.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every stage samples the previous stage's pre-edge value.
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s3_valid <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid <= bus.in_valid;
            r_s2_valid <= r_s1_valid;
            r_s3_valid <= r_s2_valid;
        end
    end

    // S1 data: sign and two's-complement magnitude (-2^31 maps to 0x8000_0000).
    always_ff @(posedge clk) begin
        // NOTE: datapath registers are not reset; the valid bits decide whether their contents mean anything.
        if (w_adv) begin
            r_s1_sign <= bus.src[31];
            r_s1_mag  <= bus.src[31] ? (~bus.src + 32'd1) : bus.src;
        end
    end

    lzc32 u_lzc (
        .i_data     (r_s1_mag),
        .o_count    (w_lz),
        .o_all_zero (w_all_zero)
    );

    assign w_norm = r_s1_mag << w_lz;

    // S2 data: shift the leading one to bit 31; exponent is 127+31-lz.
    // The magnitude is zero exactly when the source operand was zero.
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_s2_sign <= r_s1_sign;
            r_s2_zero <= w_all_zero;
            r_s2_norm <= w_norm;
            r_s2_exp  <= 8'(EXP_BIAS + INT_W - 1) - {3'b000, w_lz};
        end
    end

    // Round-to-nearest-even on the 24-bit significand; a carry out of the
    // increment renormalizes by one place and bumps the exponent.
    assign w_man24    = r_s2_norm[31:8];
    assign w_guard    = r_s2_norm[7];
    assign w_sticky   = |r_s2_norm[6:0];
    assign w_round_up = w_guard && (w_sticky || w_man24[0]);
    assign w_sum      = {1'b0, w_man24} + {24'd0, w_round_up};
    assign w_exp_rnd  = w_sum[24] ? r_s2_exp + 8'd1 : r_s2_exp;
    assign w_man_rnd  = w_sum[24] ? w_sum[23:1]    : w_sum[22:0];

    // S3 output register: zero and bubbles present +0.0 with inexact clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dest    <= '0;
            r_inexact <= 1'b0;
        end else if (w_adv) begin
            if (r_s2_valid && !r_s2_zero) begin
                r_dest    <= pack_float(r_s2_sign, w_exp_rnd, w_man_rnd);
                r_inexact <= w_guard || w_sticky;
            end else begin
                r_dest    <= '0;
                r_inexact <= 1'b0;
            end
        end
    end

    assign bus.dest      = r_dest;
    assign bus.inexact   = r_inexact;
    assign bus.out_valid = r_s3_valid;

endmodule

// File: tb/tb_itof_pipe.sv
// Self-checking bench for itof_pipe: directed vector table, backpressure and
// mid-stream reset sequences, then a randomized stream scored against an
// arithmetic reference model of int -> single conversion.
module tb_itof_pipe;

    logic clk = 1'b0;
    logic rst;

    itof_pipe_if bus ();

    itof_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] src;
        logic [31:0] dest;
        logic        inexact;
    } vec_t;

    typedef struct {
        logic [31:0] src;
        logic [32:0] want;   // {inexact, dest}
    } pend_t;

    vec_t        vecs [13];
    pend_t       exp_q [$];
    logic [31:0] bp_ops [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, want);
    endtask

    task automatic fail(input string name);
        n_checks++;
        $display("FAIL %s: got an output with no operand outstanding, want none", name);
    endtask

    // Reference: exact integer arithmetic, round half to even on the
    // quotient by 2^(e-23), where e is floor(log2|x|).
    function automatic logic [32:0] ref_itof(input logic [31:0] s);
        longint v, mag, man, rem, half, div;
        int     e;
        logic   sgn, inx;
        v   = longint'($signed(s));
        sgn = (v < 0);
        mag = sgn ? -v : v;
        if (mag == 0) return 33'h0;
        e = 0;
        while ((mag >> (e + 1)) != 0) e++;
        inx = 1'b0;
        if (e <= 23) begin
            man = mag * (longint'(1) << (23 - e));
        end else begin
            div  = longint'(1) << (e - 23);
            man  = mag / div;
            rem  = mag % div;
            half = div / 2;
            inx  = (rem != 0);
            if (rem > half || (rem == half && (man % 2) == 1)) man++;
            if (man == (longint'(1) << 24)) begin
                man = man / 2;
                e++;
            end
        end
        return {inx, sgn, 8'(e + 127), man[22:0]};
    endfunction

    // Float -> integer for exactly-representable values (inverse direction).
    function automatic longint ftoi_ref(input logic [31:0] f);
        longint m;
        int     e;
        if (f[30:0] == 31'd0) return 0;
        m = longint'({1'b1, f[22:0]});
        e = int'(f[30:23]) - 150;
        m = (e >= 0) ? (m << e) : (m >> (-e));
        return f[31] ? -m : m;
    endfunction

    function automatic logic [31:0] gen_src();
        logic [31:0] s;
        case ($urandom_range(3))
            0: s = $urandom;
            1: s = 32'($urandom_range(0, 32'h01FF_FFFF)) - 32'h0100_0000;
            2: begin
                s = (32'd1 << $urandom_range(31)) + 32'($urandom_range(0, 4)) - 32'd2;
                if ($urandom_range(1) == 1) s = -s;
            end
            default: begin
                case ($urandom_range(4))
                    0: s = 32'h0000_0000;
                    1: s = 32'h7FFF_FFFF;
                    2: s = 32'h8000_0000;
                    3: s = 32'h00FF_FFFF;
                    default: s = 32'hFFFF_FFFF;
                endcase
            end
        endcase
        return s;
    endfunction

    // One operand through an otherwise idle pipe; lat counts cycles from the
    // accept cycle to the first cycle out_valid is seen.
    task automatic run_one(input logic [31:0] s, output logic [31:0] d, output logic x, output int lat);
        @(negedge clk);
        bus.src       = s;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        d = bus.dest;
        x = bus.inexact;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1);
    end

    logic [31:0] d, held;
    logic        x, first;
    int          lat, k, got, hold, extra, n_rand;
    pend_t       p;
    logic [32:0] r;

    initial begin
        vecs[0]  = '{32'd1,          32'h3F80_0000, 1'b0};
        vecs[1]  = '{32'hFFFF_FFFF,  32'hBF80_0000, 1'b0};
        vecs[2]  = '{32'd0,          32'h0000_0000, 1'b0};
        vecs[3]  = '{32'd16777217,   32'h4B80_0000, 1'b1};
        vecs[4]  = '{32'd16777219,   32'h4B80_0002, 1'b1};
        vecs[5]  = '{32'd16777218,   32'h4B80_0001, 1'b0};
        vecs[6]  = '{32'h7FFF_FFFF,  32'h4F00_0000, 1'b1};
        vecs[7]  = '{32'h8000_0000,  32'hCF00_0000, 1'b0};
        vecs[8]  = '{32'h0100_0001,  32'h4B80_0000, 1'b1};
        vecs[9]  = '{32'h00FF_FFFF,  32'h4B7F_FFFF, 1'b0};
        vecs[10] = '{-32'd16777217,  32'hCB80_0000, 1'b1};
        vecs[11] = '{32'd3,          32'h4040_0000, 1'b0};
        vecs[12] = '{32'h4000_0000,  32'h4E80_0000, 1'b0};

        bus.src       = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        rst           = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_dest",      bus.dest,           32'd0);
        check("rst_inexact",   32'(bus.inexact),   32'd0);
        rst = 1'b0;

        // Directed vectors, idle pipe, latency on each
        for (int i = 0; i < 13; i++) begin
            run_one(vecs[i].src, d, x, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
            check($sformatf("vec%0d_dest", i),    d,        vecs[i].dest);
            check($sformatf("vec%0d_inexact", i), 32'(x),   32'(vecs[i].inexact));
        end

        // Backpressure: 5 back-to-back operands, 4-cycle hold after first result
        bp_ops = '{32'd1, 32'hFFFF_FFFF, 32'd16777219, 32'h7FFF_FFFF, 32'd12345};
        exp_q.delete();
        k = 0; got = 0; hold = 0; first = 1'b0; held = '0;
        for (int cyc = 0; cyc < 60 && got < 5; cyc++) begin
            @(negedge clk);
            if (bus.out_valid && !first) begin
                first = 1'b1;
                held  = bus.dest;
            end
            bus.in_valid  = (k < 5);
            bus.src       = bp_ops[(k < 5) ? k : 0];
            bus.out_ready = !(first && hold < 4);
            #1;
            if (!bus.out_ready) begin
                hold++;
                check("bp_in_ready_low", 32'(bus.in_ready),  32'd0);
                check("bp_out_valid",    32'(bus.out_valid), 32'd1);
                check("bp_dest_stable",  bus.dest,           held);
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back('{bp_ops[k], ref_itof(bp_ops[k])});
                k++;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) fail("bp_extra_output");
                else begin
                    p = exp_q.pop_front();
                    check($sformatf("bp_dest%0d", got),    bus.dest,          p.want[31:0]);
                    check($sformatf("bp_inexact%0d", got), 32'(bus.inexact),  32'(p.want[32]));
                end
                got++;
            end
        end
        check("bp_results", 32'(got),  32'd5);
        check("bp_hold",    32'(hold), 32'd4);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.out_valid) extra++;
        end
        check("bp_no_duplicate", 32'(extra), 32'd0);

        // Reset with two operands in flight
        @(negedge clk);
        bus.src = 32'd7; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.src = 32'd9;
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_dest",      bus.dest,           32'd0);
        check("mid_rst_inexact",   32'(bus.inexact),   32'd0);
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid) extra++;
        end
        check("mid_rst_no_stale", 32'(extra), 32'd0);
        run_one(32'd5, d, x, lat);
        r = ref_itof(32'd5);
        check("post_rst_latency", 32'(lat), 32'd3);
        check("post_rst_dest",    d,        r[31:0]);

        // Random stream with random in_valid / out_ready
        n_rand = 3000;
        exp_q.delete();
        k = 0; got = 0;
        for (int cyc = 0; cyc < 30000 && got < n_rand; cyc++) begin
            @(negedge clk);
            bus.in_valid  = (k < n_rand) && ($urandom_range(3) != 0);
            bus.src       = gen_src();
            bus.out_ready = ($urandom_range(3) != 0);
            #1;
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back('{bus.src, ref_itof(bus.src)});
                k++;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) fail("rnd_extra_output");
                else begin
                    p = exp_q.pop_front();
                    check($sformatf("rnd_dest src=0x%08h", p.src),    bus.dest,         p.want[31:0]);
                    check($sformatf("rnd_inexact src=0x%08h", p.src), 32'(bus.inexact), 32'(p.want[32]));
                    if ($signed(p.src) > -32'sd16777216 && $signed(p.src) < 32'sd16777216)
                        check($sformatf("rnd_roundtrip src=0x%08h", p.src), 32'(ftoi_ref(bus.dest)), p.src);
                end
                got++;
            end
        end
        check("rnd_results", 32'(got),          32'(n_rand));
        check("rnd_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/itof_pipe.md
Name: itof_pipe

Overview:
- Pipelined signed-int32 to IEEE-754 single conversion; inverse of the existing combinational ftoi.
- Rounding is round-to-nearest-even.
- Three register stages with a valid/ready handshake, so it can sit directly behind the FPU issue logic.
- Used with ftoi for round-trip checks on the FPU test path.

Parameters:
- none; widths fixed at 32-bit int in, 32-bit float out.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- src  input  32  signed two's-complement integer operand
- in_valid  input  1  src holds a valid operand
- in_ready  output  1  block accepts src this cycle
- dest  output  32  IEEE-754 single result {sign, exp[7:0], man[22:0]}
- inexact  output  1  result was rounded (dropped bits nonzero)
- out_valid  output  1  dest and inexact are valid
- out_ready  input  1  consumer accepts dest this cycle

Behaviour:
- Reset (rst=1 at clk edge):
  - all stage valid bits clear, so out_valid=0.
  - dest=32'h0 and inexact=0.
  - in-flight operands are discarded; reset mid-stream drops them with no output.
- Advance signal: adv = !v3 || out_ready.
  - in_ready = adv (combinational; in_ready=1 during rst).
  - When adv=1 all stages shift together: S1<=input, S2<=S1, S3<=S2, each valid bit following.
  - When adv=0 all stage registers hold (global stall); dest/out_valid stable until accepted.
  - Bubbles propagate as valid=0 entries.
- Transfers:
  - Accept on in_valid && in_ready.
  - Deliver on out_valid && out_ready.
  - Latency 3 cycles from accept to out_valid with no stall; throughput 1/cycle.
- S1 (sign/magnitude):
  - sign = src[31].
  - mag = sign ? (~src + 1) : src, as 32-bit unsigned. -2^31 gives mag = 32'h8000_0000.
  - zero flag = (src==0).
- S2 (normalize):
  - lz = leading-zero count of mag (0..31; mag=0 is don't-care).
  - norm = mag << lz, so norm[31]=1.
  - exp_pre = 8'd158 - lz  (127+31-lz).
- S3 (round, pack):
  - man24 = norm[31:8]; g = norm[7]; st = |norm[6:0].
  - Increment when g && (st || man24[0]).
  - Sum is 25 bits. If carry out: man24 = 24'h800000 and exp = exp_pre+1.
  - inexact = g | st.
  - dest = {sign, exp, man24[22:0]}.
  - zero: dest = 32'h0000_0000 (positive zero), inexact=0.
- Range: max |exp| reaches 158 (2^31), so no overflow or denormal cases exist.

Decomposition:
- Shared package fpu_pkg:
  - localparams EXP_BIAS=127, EXP_W=8, MAN_W=23, INT_W=32.
  - packed struct float_t {sign, exp, man}.
  - function pack_float.
- Sub-module lzc32:
  - combinational 32-bit leading-zero counter, output [4:0] plus all_zero.
  - Reused later by fadd normalization.
- Pipeline control (adv, valid bits) stays in itof_pipe.

Test Plan:
- Basic values, no stall, out_ready=1:
  - src=1 -> dest=0x3F800000, inexact=0, exactly 3 cycles after accept.
  - src=-1 -> 0xBF800000.
  - src=0 -> 0x00000000.
- Rounding ties (nearest-even):
  - src=16777217 (2^24+1) -> 0x4B800000, inexact=1 (tie to even, down).
  - src=16777219 -> 0x4B800002, inexact=1 (tie to even, up).
  - src=16777218 -> 0x4B800001, inexact=0.
- Extremes with carry:
  - src=0x7FFFFFFF -> 0x4F000000 (mantissa carry bumps exp), inexact=1.
  - src=0x80000000 -> 0xCF000000, inexact=0.
  - src=0x01000001 -> 0x4B800000.
- Backpressure:
  - Stream 5 operands back-to-back; hold out_ready=0 for 4 cycles after first out_valid.
  - in_ready=0 throughout the hold; dest stable.
  - All 5 results emerge in order, none lost or duplicated.
- Reset mid-operation:
  - Accept 2 operands, assert rst for 1 cycle.
  - Next cycle out_valid=0 and dest=0; no stale result ever appears.
  - A new operand after reset returns in 3 cycles.
- Random round-trip:
  - 100k $urandom src values with random in_valid/out_ready.
  - Compare dest against $shortrealtobits(shortreal'(src)).
  - For |src| < 2^24, ftoi(dest) == src.
